// File: rtl/fs_check_pkg.sv
// Shared types and sizing constants for the full-subtractor response checker.
package fs_check_pkg;

    localparam int unsigned NUM_VECTORS = 8;
    localparam int unsigned IDX_W       = 3;
    localparam int unsigned CNT_W       = 4;
    localparam int unsigned SETTLE_W    = 4;

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        SAMPLE,
        DONE
    } fs_state_t;

endpackage

// File: rtl/fs_golden_ref.sv
// Combinational golden full subtractor: a - b - bin.
module fs_golden_ref
    import fs_check_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic exp_diff,
    output logic exp_bout
);

    always_comb begin
        exp_diff = a ^ b ^ bin;
        exp_bout = (~a & b) | (~(a ^ b) & bin);
    end

endmodule

// File: rtl/fs_response_checker.sv
// Exhaustive checker for an external full subtractor: applies all 8 input
// vectors, compares responses to a golden model and counts mismatches.
// Optional first-failure log enabled by defining FS_CHECK_ERRLOG_EN.
module fs_response_checker
    import fs_check_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       bin,
    input  logic       diff,
    input  logic       b_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_cnt
`ifdef FS_CHECK_ERRLOG_EN
    ,
    output logic       first_fail_vld,
    output logic [2:0] first_fail_vec
`endif
);

    fs_state_t           state;
    fs_state_t           state_nxt;
    logic [IDX_W-1:0]    idx;
    logic [SETTLE_W-1:0] settle_cnt;
    logic                exp_diff;
    logic                exp_bout;
    logic                mismatch;
    logic                settled;
    logic                last_vec;

    fs_golden_ref u_golden_ref (
        .a        (a),
        .b        (b),
        .bin      (bin),
        .exp_diff (exp_diff),
        .exp_bout (exp_bout)
    );

    always_comb begin
        mismatch = (diff != exp_diff) || (b_out != exp_bout);
        settled  = (settle_cnt == SETTLE_W'(SETTLE_CYCLES - 1));
        last_vec = (idx == IDX_W'(NUM_VECTORS - 1));
        busy     = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = APPLY;
            APPLY:   if (settled) state_nxt = SAMPLE;
            SAMPLE:  state_nxt = last_vec ? DONE : APPLY;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Stimulus is registered and advanced on leaving SAMPLE, so {a,b,bin}
    // already equals idx for the whole APPLY window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx          <= '0;
            settle_cnt   <= '0;
            {a, b, bin}  <= '0;
            done         <= 1'b0;
            pass         <= 1'b0;
            err_cnt      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        idx         <= '0;
                        settle_cnt  <= '0;
                        {a, b, bin} <= '0;
                        pass        <= 1'b0;
                        err_cnt     <= '0;
                    end
                end
                APPLY: begin
                    settle_cnt <= settled ? '0 : settle_cnt + 1'b1;
                end
                SAMPLE: begin
                    if (mismatch && (err_cnt < CNT_W'(NUM_VECTORS)))
                        err_cnt <= err_cnt + 1'b1;
                    if (!last_vec) begin
                        idx         <= idx + 1'b1;
                        {a, b, bin} <= idx + 1'b1;
                    end
                end
                DONE: begin
                    done <= 1'b1;
                    pass <= (err_cnt == '0);
                end
                default: ;
            endcase
        end
    end

`ifdef FS_CHECK_ERRLOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_fail_vld <= 1'b0;
            first_fail_vec <= '0;
        end else if (state == IDLE && start) begin
            first_fail_vld <= 1'b0;
            first_fail_vec <= '0;
        end else if (state == SAMPLE && mismatch && !first_fail_vld) begin
            first_fail_vld <= 1'b1;
            first_fail_vec <= idx;
        end
    end
`endif

endmodule

// File: tb/tb_fs_response_checker.sv
// Scoreboard bench for fs_response_checker: two instances (settle 1 and 3)
// drive fault-injected behavioural subtractors; a monitor checks each done.
module tb_fs_response_checker;

    localparam int unsigned SV [2] = '{1, 3};

    typedef struct {
        int unsigned err;
        bit          pass;
        bit          fvld;
        int unsigned first;
        int unsigned done_cyc;
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        a [2], b [2], bin [2], diff [2], bout [2];
    logic        busy [2], done [2], pass [2];
    logic [3:0]  err [2];
    logic [7:0]  fd [2], fb [2];
`ifdef FS_CHECK_ERRLOG_EN
    logic        ffv [2];
    logic [2:0]  ffvec [2];
`endif

    int unsigned cyc = 0;
    int unsigned n_tests = 0;
    int unsigned n_fail = 0;
    int unsigned last_err [2];
    bit          last_pass [2];
    exp_t        sb [2][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference subtractor from plain arithmetic: r = a - b - bin.
    function automatic bit ref_diff(input int x, input int y, input int z);
        int r;
        r = x - y - z;
        return (r % 2) != 0;
    endfunction

    function automatic bit ref_bout(input int x, input int y, input int z);
        return (x - y - z) < 0;
    endfunction

    always_comb begin
        for (int k = 0; k < 2; k++) begin
            diff[k] = ref_diff(int'(a[k]), int'(b[k]), int'(bin[k])) ^ fd[k][{a[k], b[k], bin[k]}];
            bout[k] = ref_bout(int'(a[k]), int'(b[k]), int'(bin[k])) ^ fb[k][{a[k], b[k], bin[k]}];
        end
    end

    fs_response_checker #(.SETTLE_CYCLES(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a(a[0]), .b(b[0]), .bin(bin[0]), .diff(diff[0]), .b_out(bout[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]), .err_cnt(err[0])
`ifdef FS_CHECK_ERRLOG_EN
        , .first_fail_vld(ffv[0]), .first_fail_vec(ffvec[0])
`endif
    );

    fs_response_checker #(.SETTLE_CYCLES(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a(a[1]), .b(b[1]), .bin(bin[1]), .diff(diff[1]), .b_out(bout[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]), .err_cnt(err[1])
`ifdef FS_CHECK_ERRLOG_EN
        , .first_fail_vld(ffv[1]), .first_fail_vec(ffvec[1])
`endif
    );

    task automatic chk(input string nm, input int k, input int unsigned act, input int unsigned expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0d expected %0d (cycle %0d)", nm, k, act, expv, cyc);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] md, input logic [7:0] mb, input int unsigned dc);
        exp_t        e;
        logic [7:0]  m;
        m = md | mb;
        e.err = $countones(m);
        if (e.err > 8) e.err = 8;
        e.pass = (e.err == 0);
        e.fvld = 1'b0;
        e.first = 0;
        for (int v = 7; v >= 0; v--) begin
            if (m[v]) begin
                e.fvld = 1'b1;
                e.first = v;
            end
        end
        e.done_cyc = dc;
        return e;
    endfunction

    // Monitors: stimulus order/hold while busy, and scoreboard pop on done.
    for (genvar k = 0; k < 2; k++) begin : g_mon
        int unsigned hk = 0;
        bit          vec_bad = 1'b0;
        initial begin
            exp_t e;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    hk = 0;
                    vec_bad = 1'b0;
                end else begin
                    if (busy[k] && hk < 8 * (SV[k] + 1)) begin
                        if ({a[k], b[k], bin[k]} != 3'(hk / (SV[k] + 1))) vec_bad = 1'b1;
                        hk++;
                    end
                    if (done[k]) begin
                        chk("done_expected", k, sb[k].size() != 0, 1);
                        if (sb[k].size() != 0) begin
                            e = sb[k].pop_front();
                            chk("err_cnt", k, err[k], e.err);
                            chk("pass", k, pass[k], e.pass);
                            chk("latency", k, cyc, e.done_cyc);
                            chk("busy_at_done", k, busy[k], 0);
                            chk("vec_order", k, vec_bad, 0);
`ifdef FS_CHECK_ERRLOG_EN
                            chk("first_fail_vld", k, ffv[k], e.fvld);
                            if (e.fvld) chk("first_fail_vec", k, ffvec[k], e.first);
`endif
                        end
                        hk = 0;
                        vec_bad = 1'b0;
                    end
                end
            end
        end
    end

    task automatic run_check(input logic [7:0] md0, input logic [7:0] mb0,
                             input logic [7:0] md1, input logic [7:0] mb1, input bit repulse);
        exp_t e;
        fd[0] = md0; fb[0] = mb0; fd[1] = md1; fb[1] = mb1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("idle_hold_err", k, err[k], last_err[k]);
            chk("idle_hold_pass", k, pass[k], last_pass[k]);
        end
        start = 1'b1;
        for (int k = 0; k < 2; k++) begin
            e = mk(fd[k], fb[k], cyc + 1 + 8 * (SV[k] + 1) + 1);
            sb[k].push_back(e);
            last_err[k] = e.err;
            last_pass[k] = e.pass;
        end
        @(negedge clk);
        start = 1'b0;
        if (repulse) begin
            repeat (3) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        for (int t = 0; t < 120; t++) begin
            if (sb[0].size() == 0 && sb[1].size() == 0) break;
            @(negedge clk);
        end
        for (int k = 0; k < 2; k++) begin
            chk("done_timeout", k, sb[k].size(), 0);
            sb[k].delete();
        end
    endtask

    initial begin
        logic [7:0] dmask, bmask;
        dmask = '0;
        bmask = '0;
        for (int v = 0; v < 8; v++) begin
            dmask[v] = ref_diff(v / 4, (v / 2) % 2, v % 2);
            bmask[v] = ref_bout(v / 4, (v / 2) % 2, v % 2);
        end
        fd[0] = '0; fb[0] = '0; fd[1] = '0; fb[1] = '0;
        for (int k = 0; k < 2; k++) begin
            last_err[k] = 0;
            last_pass[k] = 1'b0;
        end

        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++)
            chk("reset_state", k, {a[k], b[k], bin[k], busy[k], done[k], pass[k], err[k]}, 0);
        rst_n = 1'b1;

        run_check('0, '0, '0, '0, 1'b0);
        run_check(dmask, '0, dmask, '0, 1'b0);
        run_check('0, bmask, '0, bmask, 1'b0);
        run_check(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0);
        run_check('0, '0, '0, '0, 1'b1);

        // Mid-run reset: outputs clear at once and the aborted run never completes.
        fd[0] = $urandom; fb[0] = '0; fd[1] = '0; fb[1] = '0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("midrun_reset", k, {a[k], b[k], bin[k], busy[k], done[k], pass[k], err[k]}, 0);
            last_err[k] = 0;
            last_pass[k] = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        for (int k = 0; k < 2; k++) chk("idle_after_reset", k, busy[k], 0);

        for (int r = 0; r < 12; r++) begin
            logic [7:0] m [4];
            for (int j = 0; j < 4; j++) begin
                case ($urandom_range(0, 3))
                    0:       m[j] = '0;
                    1:       m[j] = 8'($urandom) & 8'($urandom);
                    default: m[j] = 8'($urandom);
                endcase
            end
            run_check(m[0], m[1], m[2], m[3], 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
